cpu_core_mc: RTL



---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/cpu_core_mc_if.sv | 14 +
 rtl/cpu_regfile.sv | 39 +++
 rtl/cpu_core_mc.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU core and its assembler test tables.
package cpu_pkg;

    localparam int unsigned INSTR_WIDTH = 16;
    localparam int unsigned RETIRED_W   = 16;
    localparam int unsigned REG_ADDR_W  = 3;
    localparam int unsigned NUM_REGS    = 8;
    localparam int unsigned IMM6_W      = 6;
    localparam int unsigned IMM9_W      = 9;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_LDI  = 4'h7;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_BZ   = 4'hA;
    localparam logic [3:0] OP_BP   = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_EXEC   = 2'd1,
        S_MEM    = 2'd2,
        S_HALTED = 2'd3
    } state_e;

    // Field layout of an instruction word; immediates overlay rs/rt/fn.
    typedef struct packed {
        logic [3:0]            op;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [2:0]            fn;
    } instr_t;

endpackage

// File: rtl/cpu_core_mc_if.sv
// Program-memory fetch handshake between the core and external instruction memory.
interface cpu_core_mc_if
    import cpu_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 6
);
    logic                   req;
    logic [PC_WIDTH-1:0]    addr;
    logic                   valid;
    logic [INSTR_WIDTH-1:0] data;

    modport master (output req, output addr, input valid, input data);
    modport slave  (input req, input addr, output valid, output data);
endinterface

// File: rtl/cpu_regfile.sv
// Eight-entry register file: three asynchronous read ports, one synchronous write port.
module cpu_regfile
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] wa,
    input  logic [DATA_WIDTH-1:0] wd,
    input  logic [REG_ADDR_W-1:0] ra_s,
    input  logic [REG_ADDR_W-1:0] ra_t,
    input  logic [REG_ADDR_W-1:0] ra_d,
    output logic [DATA_WIDTH-1:0] rs_val,
    output logic [DATA_WIDTH-1:0] rt_val,
    output logic [DATA_WIDTH-1:0] rd_val,
    output logic [DATA_WIDTH-1:0] r7
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Register storage, cleared on reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[wa] <= wd;
        end
    end

    assign rs_val = regs[ra_s];
    assign rt_val = regs[ra_t];
    assign rd_val = regs[ra_d];
    assign r7     = regs[NUM_REGS-1];

endmodule

// File: rtl/cpu_core_mc.sv
// Multi-cycle CPU core: FETCH/EXEC/MEM/HALTED sequencer, ALU and internal data memory.
module cpu_core_mc
    import cpu_pkg::*;
#(
    parameter int unsigned PC_WIDTH   = 6,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DMEM_DEPTH = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  run,
    cpu_core_mc_if.master         imem,
    output logic [PC_WIDTH-1:0]   PC_out,
    output logic [DATA_WIDTH-1:0] r7_data,
    output logic                  halted,
    output logic [RETIRED_W-1:0]  retired
);

    localparam int unsigned DADDR_W = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
    localparam int unsigned OFF_W   = (PC_WIDTH > IMM9_W) ? PC_WIDTH : IMM9_W;

    state_e                 state, state_nxt;
    logic [PC_WIDTH-1:0]    pc, pc_nxt, pc_inc, pc_br;
    instr_t                 ir;
    logic [RETIRED_W-1:0]   retired_q;
    logic                   ir_load, retire, rf_we, dmem_we;
    logic [DATA_WIDTH-1:0]  rf_wd, rs_val, rt_val, rd_val;
    logic [DATA_WIDTH-1:0]  imm6_x, imm9_x, alu_res, dmem_q;
    logic [DADDR_W-1:0]     dmem_addr;
    logic [DATA_WIDTH-1:0]  dmem [DMEM_DEPTH];

    cpu_regfile #(.DATA_WIDTH(DATA_WIDTH)) u_regfile (
        .clock   (clock),
        .reset_n (reset_n),
        .we      (rf_we),
        .wa      (ir.rd),
        .wd      (rf_wd),
        .ra_s    (ir.rs),
        .ra_t    (ir.rt),
        .ra_d    (ir.rd),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .rd_val  (rd_val),
        .r7      (r7_data)
    );

    assign imm6_x    = DATA_WIDTH'($signed(ir[IMM6_W-1:0]));
    assign imm9_x    = DATA_WIDTH'($signed(ir[IMM9_W-1:0]));
    assign pc_inc    = pc + PC_WIDTH'(1);
    assign pc_br     = pc + PC_WIDTH'(OFF_W'($signed(ir[IMM9_W-1:0])));
    assign dmem_addr = DADDR_W'(rs_val + imm6_x);

    // ALU result for register-writing EXEC instructions.
    always_comb begin
        alu_res = rs_val + rt_val;
        case (ir.op)
            OP_SUB:  alu_res = rs_val - rt_val;
            OP_AND:  alu_res = rs_val & rt_val;
            OP_OR:   alu_res = rs_val | rt_val;
            OP_XOR:  alu_res = rs_val ^ rt_val;
            OP_ADDI: alu_res = rs_val + imm6_x;
            OP_LDI:  alu_res = imm9_x;
            default: ;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-state commit controls.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_load   = 1'b0;
        retire    = 1'b0;
        rf_we     = 1'b0;
        rf_wd     = alu_res;
        dmem_we   = 1'b0;
        case (state)
            S_FETCH: begin
                if (imem.valid) begin
                    ir_load   = 1'b1;
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                state_nxt = S_FETCH;
                pc_nxt    = pc_inc;
                retire    = 1'b1;
                case (ir.op)
                    OP_NOP: ;
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI, OP_LDI: rf_we = 1'b1;
                    OP_LD: begin
                        state_nxt = S_MEM;
                        pc_nxt    = pc;
                        retire    = 1'b0;
                    end
                    OP_ST:   dmem_we = 1'b1;
                    OP_BZ:   if (rd_val == '0) pc_nxt = pc_br;
                    OP_BP:   if (!rd_val[DATA_WIDTH-1] && (rd_val != '0)) pc_nxt = pc_br;
                    OP_JMP:  pc_nxt = ir[PC_WIDTH-1:0];
                    OP_HALT: state_nxt = S_HALTED;
                    default: ;
                endcase
            end
            S_MEM: begin
                rf_we     = 1'b1;
                rf_wd     = dmem_q;
                pc_nxt    = pc_inc;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_HALTED: begin
                if (run) state_nxt = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    // PC, instruction register and retired counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc        <= '0;
            ir        <= '0;
            retired_q <= '0;
        end else begin
            pc <= pc_nxt;
            if (ir_load) ir <= instr_t'(imem.data);
            if (retire)  retired_q <= retired_q + RETIRED_W'(1);
        end
    end

    // Data memory with registered read; LD captures its word on the EXEC edge.
    always_ff @(posedge clock) begin
        if (dmem_we) dmem[dmem_addr] <= rd_val;
        dmem_q <= dmem[dmem_addr];
    end

    // Request is masked while reset is held so it reads 0, and rises right at release.
    assign imem.req  = reset_n && (state == S_FETCH);
    assign imem.addr = pc;
    assign PC_out    = pc;
    assign halted    = (state == S_HALTED);
    assign retired   = retired_q;

endmodule
